// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline, tracked with EX/MEM/WB shadow stages.
// Define HAZARD_FWD_EN to forward MEM/WB results; when it is undefined, RAW hazards are resolved by stalling only.
module hazard_fwd_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        stall,
    output logic [15:0] stall_count
);

    logic       ex_valid_q, ex_regwrite_q, ex_memread_q, ex_uses_rt_q;
    logic [4:0] ex_rd_q, ex_rs_q, ex_rt_q;
    logic       mem_valid_q, mem_regwrite_q, mem_memread_q;
    logic [4:0] mem_rd_q;
    logic       wb_valid_q, wb_regwrite_q, wb_memread_q;
    logic [4:0] wb_rd_q;
    logic [15:0] stall_count_q, stall_count_d;

    logic ex_wr, mem_wr;
    logic ex_hits_id, mem_hits_id;
    logic ex_load;

    // Writes to r0 are architecturally discarded, so they never count as producers.
    assign ex_wr  = ex_valid_q  & ex_regwrite_q  & (ex_rd_q  != 5'd0);
    assign mem_wr = mem_valid_q & mem_regwrite_q & (mem_rd_q != 5'd0);

    assign ex_hits_id  = (ex_rd_q == id_rs)  | (id_uses_rt & (ex_rd_q == id_rt));
    assign mem_hits_id = (mem_rd_q == id_rs) | (id_uses_rt & (mem_rd_q == id_rt));

`ifdef HAZARD_FWD_EN
    logic wb_wr;
    assign wb_wr = wb_valid_q & wb_regwrite_q & (wb_rd_q != 5'd0);

    // MEM is checked first so the youngest producer wins when both match.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (ex_valid_q) begin
            if (mem_wr && (mem_rd_q == ex_rs_q))
                fwd_a_sel = 2'b10;
            else if (wb_wr && (wb_rd_q == ex_rs_q))
                fwd_a_sel = 2'b01;

            if (ex_uses_rt_q) begin
                if (mem_wr && (mem_rd_q == ex_rt_q))
                    fwd_b_sel = 2'b10;
                else if (wb_wr && (wb_rd_q == ex_rt_q))
                    fwd_b_sel = 2'b01;
            end
        end
    end

    // Only a load in EX cannot be forwarded in time; one bubble lets it reach MEM.
    assign stall = id_valid & ex_wr & ex_memread_q & ex_hits_id;
`else
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
    // The register file is write-first, so a WB producer is already visible in ID.
    assign stall = id_valid & ((ex_wr & ex_hits_id) | (mem_wr & mem_hits_id));
`endif

    logic unused_shadow;
    assign unused_shadow = ^{mem_memread_q, wb_memread_q, wb_valid_q, wb_regwrite_q, wb_rd_q,
                             ex_rs_q, ex_rt_q, ex_uses_rt_q, ex_memread_q, mem_hits_id};

    assign ex_load       = id_valid & ~stall;
    assign stall_count_d = (stall && (stall_count_q != 16'hFFFF)) ? stall_count_q + 16'd1
                                                                  : stall_count_q;
    assign stall_count   = stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_uses_rt_q   <= 1'b0;
            ex_rd_q        <= 5'd0;
            ex_rs_q        <= 5'd0;
            ex_rt_q        <= 5'd0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            mem_rd_q       <= 5'd0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_memread_q   <= 1'b0;
            wb_rd_q        <= 5'd0;
            stall_count_q  <= 16'd0;
        end else begin
            wb_valid_q     <= mem_valid_q;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_memread_q   <= mem_memread_q;
            wb_rd_q        <= mem_rd_q;
            mem_valid_q    <= ex_valid_q;
            mem_regwrite_q <= ex_regwrite_q;
            mem_memread_q  <= ex_memread_q;
            mem_rd_q       <= ex_rd_q;
            if (ex_load) begin
                ex_valid_q    <= 1'b1;
                ex_regwrite_q <= id_regwrite;
                ex_memread_q  <= id_memread;
                ex_uses_rt_q  <= id_uses_rt;
                ex_rd_q       <= id_rd;
                ex_rs_q       <= id_rs;
                ex_rt_q       <= id_rt;
            end else begin
                ex_valid_q    <= 1'b0;
                ex_regwrite_q <= 1'b0;
                ex_memread_q  <= 1'b0;
                ex_uses_rt_q  <= 1'b0;
                ex_rd_q       <= 5'd0;
                ex_rs_q       <= 5'd0;
                ex_rt_q       <= 5'd0;
            end
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed pipeline scenarios plus random instruction streams against a queue-style model.
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rt, id_regwrite, id_memread;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_fwd_unit dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .stall_count(stall_count)
    );

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } instr_t;

    // In-flight instructions, youngest first: [0]=EX, [1]=MEM, [2]=WB.
    instr_t pipe [3];
    int     model_cnt;
    int     n_cmp = 0;
    int     n_bad = 0;
    logic [1:0] obs_a, obs_b;
    logic       obs_stall, exp_stall_last;
    logic [15:0] obs_cnt;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input int rd, input int rs, input int rt, input bit uses_rt,
                                  input bit regwrite, input bit memread);
        instr_t i;
        i.valid = 1'b1; i.rd = 5'(rd); i.rs = 5'(rs); i.rt = 5'(rt);
        i.uses_rt = uses_rt; i.regwrite = regwrite; i.memread = memread;
        return i;
    endfunction

    function automatic bit writes(input instr_t i);
        return i.valid && i.regwrite && (i.rd != 5'd0);
    endfunction

    function automatic logic [1:0] exp_sel(input logic [4:0] r, input bit used);
        logic [1:0] s = 2'b00;
        if (pipe[0].valid && used) begin
            if (writes(pipe[1]) && pipe[1].rd == r) s = 2'b10;
            else if (writes(pipe[2]) && pipe[2].rd == r) s = 2'b01;
        end
`ifndef HAZARD_FWD_EN
        s = 2'b00;
`endif
        return s;
    endfunction

    function automatic bit exp_stall(input instr_t id);
        bit s = 0;
`ifdef HAZARD_FWD_EN
        int depth = 1;
`else
        int depth = 2;
`endif
        for (int k = 0; k < depth; k++) begin
            if (writes(pipe[k]) && (pipe[k].rd == id.rs || (id.uses_rt && pipe[k].rd == id.rt))) begin
`ifdef HAZARD_FWD_EN
                if (pipe[k].memread) s = 1;
`else
                s = 1;
`endif
            end
        end
        return id.valid && s;
    endfunction

    task automatic drive(input instr_t i);
        id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_uses_rt = i.uses_rt;
        id_rd = i.rd; id_regwrite = i.regwrite; id_memread = i.memread;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        model_cnt = 0;
    endtask

    // One clock: present ins in ID, compare all outputs mid-cycle, then advance the model.
    task automatic step(input instr_t ins);
        bit es;
        drive(ins);
        @(negedge clk);
        es = exp_stall(ins);
        obs_a = fwd_a_sel; obs_b = fwd_b_sel; obs_stall = stall; obs_cnt = stall_count;
        check("stall", {15'd0, stall}, {15'd0, es});
        check("fwd_a", {14'd0, fwd_a_sel}, {14'd0, exp_sel(pipe[0].rs, 1'b1)});
        check("fwd_b", {14'd0, fwd_b_sel}, {14'd0, exp_sel(pipe[0].rt, pipe[0].uses_rt)});
        check("stall_count", stall_count, 16'(model_cnt));
        exp_stall_last = es;
        @(posedge clk);
        if (es && model_cnt < 65535) model_cnt++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (!es && ins.valid) ? ins : '0;
        #1;
    endtask

    task automatic flush();
        repeat (3) step('0);
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid    = ($urandom_range(7) != 0);
        i.rs       = 5'($urandom_range(7));
        i.rt       = 5'($urandom_range(7));
        i.rd       = 5'($urandom_range(7));
        i.uses_rt  = 1'($urandom_range(1));
        i.regwrite = ($urandom_range(3) != 0);
        i.memread  = i.regwrite && ($urandom_range(2) == 0);
        return i;
    endfunction

    task automatic random_run(input int n);
        instr_t cur = rand_instr();
        for (int c = 0; c < n; c++) begin
            step(cur);
            if (!exp_stall_last) cur = rand_instr();
        end
    endtask

    initial begin
        instr_t nop = '0;
        model_reset();
        rst_n = 1'b0;
        drive(mk(3, 3, 3, 1, 1, 1));
        #2;
        check("rst_stall", {15'd0, stall}, 16'd0);
        check("rst_fwd_a", {14'd0, fwd_a_sel}, 16'd0);
        check("rst_fwd_b", {14'd0, fwd_b_sel}, 16'd0);
        check("rst_count", stall_count, 16'd0);
        drive(nop);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load followed by a dependent add.
        step(mk(8, 1, 0, 0, 1, 1));
        step(mk(9, 8, 8, 1, 1, 0));
        check("lu_stall1", {15'd0, obs_stall}, 16'd1);
        step(mk(9, 8, 8, 1, 1, 0));
`ifdef HAZARD_FWD_EN
        check("lu_stall_end", {15'd0, obs_stall}, 16'd0);
        step(nop);
        check("lu_fwd_a", {14'd0, obs_a}, 16'd1);
        check("lu_fwd_b", {14'd0, obs_b}, 16'd1);
        check("lu_count", obs_cnt, 16'd1);
`else
        check("lu_stall2", {15'd0, obs_stall}, 16'd1);
        step(mk(9, 8, 8, 1, 1, 0));
        check("lu_stall_end", {15'd0, obs_stall}, 16'd0);
        check("lu_count", obs_cnt, 16'd2);
`endif

        // add r3,r1,r2 ; sub r4,r3,r5
        flush();
        step(mk(3, 1, 2, 1, 1, 0));
        step(mk(4, 3, 5, 1, 1, 0));
`ifdef HAZARD_FWD_EN
        check("b2b_stall", {15'd0, obs_stall}, 16'd0);
        step(nop);
        check("b2b_fwd_a", {14'd0, obs_a}, 16'd2);
`else
        check("b2b_stall1", {15'd0, obs_stall}, 16'd1);
        check("b2b_sel_a1", {14'd0, obs_a}, 16'd0);
        step(mk(4, 3, 5, 1, 1, 0));
        check("b2b_stall2", {15'd0, obs_stall}, 16'd1);
        check("b2b_sel_b2", {14'd0, obs_b}, 16'd0);
        step(mk(4, 3, 5, 1, 1, 0));
        check("b2b_stall_end", {15'd0, obs_stall}, 16'd0);
        step(nop);
        check("b2b_sel_a", {14'd0, obs_a}, 16'd0);
`endif

        // add r3 ; nop ; or r6,r7,r3
        flush();
        step(mk(3, 1, 2, 1, 1, 0));
        step(nop);
        step(mk(6, 7, 3, 1, 1, 0));
`ifdef HAZARD_FWD_EN
        step(nop);
        check("gap_fwd_b", {14'd0, obs_b}, 16'd1);
        check("gap_fwd_a", {14'd0, obs_a}, 16'd0);
`else
        check("gap_stall", {15'd0, obs_stall}, 16'd1);
`endif

        // Producer of r0 never creates a dependency.
        flush();
        step(mk(0, 1, 2, 1, 1, 1));
        step(mk(4, 0, 0, 1, 1, 0));
        check("r0_stall", {15'd0, obs_stall}, 16'd0);
        step(nop);
        check("r0_fwd_a", {14'd0, obs_a}, 16'd0);
        check("r0_fwd_b", {14'd0, obs_b}, 16'd0);

        random_run(400);

        // Reset asserted while a load-use stall is active.
        flush();
        step(mk(8, 1, 0, 0, 1, 1));
        drive(mk(9, 8, 8, 1, 1, 0));
        @(negedge clk);
        check("mid_stall_before", {15'd0, stall}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_stall", {15'd0, stall}, 16'd0);
        check("mid_rst_fwd_a", {14'd0, fwd_a_sel}, 16'd0);
        check("mid_rst_fwd_b", {14'd0, fwd_b_sel}, 16'd0);
        check("mid_rst_count", stall_count, 16'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("in_rst_stall", {15'd0, stall}, 16'd0);
        rst_n = 1'b1;

        random_run(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
